row_element_issuer: RTL and testbench
=====================================

# row_element_issuer

Producer side of the accumulator element bus. It takes row descriptors (non-zero-element count, NZE) and a stream of 24-bit product values, and drives the `element` / `set_bit` pair consumed by the accumulator controller. It marks the first element of each row with `set_bit` and the last with tag bit 24. After each row it inserts idle cycles so the 4-deep adder pipeline drains before the next row starts.

## Interface
Parameters:
- `ELEM_W`, 24: product value width; `element` is `ELEM_W+1` bits.
- `NZE_W`, 4: width of the row NZE count (max 15 elements per row).
- `DRAIN_CYCLES`, 4: idle words inserted after each row's last element; legal range 1..15.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `row_valid`  in  1  row descriptor offered.
- `row_nze`  in  NZE_W  number of elements in the offered row (0 legal).
- `row_ready`  out  1  descriptor accepted when `row_valid && row_ready` at a rising edge.
- `elem_valid_in`  in  1  product value offered.
- `elem_data_in`  in  ELEM_W  product value.
- `elem_ready_in`  out  1  value accepted when `elem_valid_in && elem_ready_in`.
- `element`  out  ELEM_W+1  bus word: [24] last-of-row tag, [23:0] value; 25'h0 means idle.
- `set_bit`  out  1  first word of a row; valid only alongside a non-zero `element`.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN (state enum in the package).
- IDLE:
  - `row_ready`=1, `elem_ready_in`=0, `element`/`set_bit` driven to 0.
  - On a row handshake: load `remaining`←`row_nze`, set `first_pending`←1.
  - If `row_nze`≠0, go to ISSUE.
  - If `row_nze`=0, emit the empty-row word 25'h1000000 with `set_bit`=1 on that same edge, load the drain counter, and go to DRAIN.
- ISSUE:
  - `elem_ready_in`=1 and `row_ready`=0; both are combinational decodes of the state.
  - Each accepted value decrements `remaining`.
  - When the accepted value is the last one (`remaining`==1):
    - Emit `{1'b1, data}` with `set_bit`=`first_pending`.
    - Load the drain counter with DRAIN_CYCLES and go to DRAIN.
  - When the value is not last and its data is non-zero: emit `{1'b0, data}` with `set_bit`=`first_pending`, then clear `first_pending`.
  - When the value is not last and its data is zero:
    - Consume it and emit an idle word (25'h0). A zero non-last word would collide with the idle encoding and does not change the sum.
    - `first_pending` stays set, so `set_bit` moves to the next emitted word.
  - A last value with zero data emits 25'h1000000. The tag keeps it non-idle.
  - Cycles with no accepted value emit 25'h0 with `set_bit`=0.
- DRAIN:
  - Emit 25'h0 each cycle and decrement the drain counter.
  - At count 1, go to IDLE.
  - `row_valid` is ignored while in DRAIN.
- Invariant: exactly one word per row carries `set_bit` and exactly one carries bit 24; for non-empty rows with all-zero data these can be the same word.

## Timing
- All outputs except `row_ready`/`elem_ready_in` are registered.
- Reset values: `element`=0, `set_bit`=0, `busy`=0, state IDLE, `row_ready`=1. `elem_ready_in`=0.
- Accept-to-output latency: 1 cycle. A value accepted at edge n appears on `element` after edge n.
- Descriptor accepted at edge k: ISSUE from k, first value acceptable at edge k+1.
- Row throughput: last word at edge m, idle words at edges m+1..m+DRAIN_CYCLES, `row_ready` high after edge m+DRAIN_CYCLES. Next descriptor no earlier than edge m+DRAIN_CYCLES+1.
- Reset mid-row: outputs clear immediately (asynchronous). The partial row is discarded with no tag word. The next row starts cleanly with `set_bit`.
- `remaining` never wraps. It is only decremented in ISSUE, where it is ≥1.

## Structure
- Shared package `ams_pkg`:
  - `ELEM_W`, `LAST_BIT`=24, `IDLE_WORD`=25'h0, `EMPTY_ROW_WORD`=25'h1000000.
  - State typedef `issuer_state_t`.
- One module, no sub-modules. The drain counter is inline (4 bits), not worth a separate block.

## Test plan
- nze=3, values 5,7,9 back-to-back → words 0x0000005 (`set_bit`=1), 0x0000007, 0x1000009; then 4 × 0x0; `row_ready` high after the 4th.
- nze=0 → single 0x1000000 with `set_bit`=1, 4 idle words, back to IDLE.
- nze=3, values 0,0,6 → two idle words, then 0x1000006 with `set_bit`=1.
- nze=2, values 3 then (3 stall cycles) 4 → 0x0000003 (`set_bit`=1), 3 idle words, 0x1000004 (`set_bit`=0).
- nze=15, values 1..15 with `row_valid` held high throughout → 15 words, tag only on 0x100000F; second descriptor accepted only after the drain completes.
- `reset` pulsed after 2 of 5 values → `element`/`set_bit` zero immediately; after release, an nze=1 row with value 8 → 0x1000008 with `set_bit`=1.

Source files
------------

// File: rtl/ams_pkg.sv
// Shared definitions for the accumulator element bus: word encodings and issuer state.
package ams_pkg;

   localparam int unsigned ELEM_W = 24;
   localparam int unsigned LAST_BIT = 24;
   localparam logic [ELEM_W:0] IDLE_WORD = 25'h0;
   localparam logic [ELEM_W:0] EMPTY_ROW_WORD = 25'h1000000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } issuer_state_t;

endpackage

// File: rtl/row_element_issuer.sv
// Producer for the accumulator element bus: tags first/last word of each row and
// pads every row with idle words so the adder pipeline drains between rows.
module row_element_issuer
   import ams_pkg::*;
#(
   parameter int unsigned ELEM_W = 24,
   parameter int unsigned NZE_W = 4,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              row_valid,
   input  logic [NZE_W-1:0]  row_nze,
   output logic              row_ready,
   input  logic              elem_valid_in,
   input  logic [ELEM_W-1:0] elem_data_in,
   output logic              elem_ready_in,
   output logic [ELEM_W:0]   element,
   output logic              set_bit,
   output logic              busy
);

   localparam int unsigned DRAIN_W = 4;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
   localparam logic [ELEM_W:0] IDLE_W = (ELEM_W+1)'(0);
   localparam logic [ELEM_W:0] EMPTY_W = {1'b1, {ELEM_W{1'b0}}};

   issuer_state_t      state;
   logic [NZE_W-1:0]   remaining;
   logic               first_pending;
   logic [DRAIN_W-1:0] drain_cnt;

   // Handshake readies are pure decodes of the state register.
   assign row_ready     = (state == IDLE);
   assign elem_ready_in = (state == ISSUE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         remaining     <= '0;
         first_pending <= 1'b0;
         drain_cnt     <= '0;
         element       <= IDLE_W;
         set_bit       <= 1'b0;
         busy          <= 1'b0;
      end else begin
         element <= IDLE_W;
         set_bit <= 1'b0;
         case (state)
            IDLE: begin
               if (row_valid) begin
                  remaining     <= row_nze;
                  first_pending <= 1'b1;
                  busy          <= 1'b1;
                  if (row_nze != '0) begin
                     state <= ISSUE;
                  end else begin
                     // Empty row still needs one tagged word so the consumer closes it.
                     element   <= EMPTY_W;
                     set_bit   <= 1'b1;
                     drain_cnt <= DRAIN_LOAD;
                     state     <= DRAIN;
                  end
               end
            end
            ISSUE: begin
               if (elem_valid_in) begin
                  remaining <= remaining - NZE_W'(1);
                  if (remaining == NZE_W'(1)) begin
                     element   <= {1'b1, elem_data_in};
                     set_bit   <= first_pending;
                     drain_cnt <= DRAIN_LOAD;
                     state     <= DRAIN;
                  end else if (elem_data_in != '0) begin
                     element       <= {1'b0, elem_data_in};
                     set_bit       <= first_pending;
                     first_pending <= 1'b0;
                  end
                  // Zero non-last values are dropped; set_bit moves to the next real word.
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - DRAIN_W'(1);
               if (drain_cnt == DRAIN_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_row_element_issuer.sv
// Directed bench for row_element_issuer with an expected-word scoreboard.
module tb_row_element_issuer;

   logic        clock = 1'b0;
   logic        reset;
   logic        row_valid;
   logic [3:0]  row_nze;
   logic        row_ready;
   logic        elem_valid_in;
   logic [23:0] elem_data_in;
   logic        elem_ready_in;
   logic [24:0] element;
   logic        set_bit;
   logic        busy;

   int compared = 0;
   int mismatched = 0;
   logic [25:0] sb_q[$];

   row_element_issuer #(.ELEM_W(24), .NZE_W(4), .DRAIN_CYCLES(4)) dut (
      .clock(clock),
      .reset(reset),
      .row_valid(row_valid),
      .row_nze(row_nze),
      .row_ready(row_ready),
      .elem_valid_in(elem_valid_in),
      .elem_data_in(elem_data_in),
      .elem_ready_in(elem_ready_in),
      .element(element),
      .set_bit(set_bit),
      .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Push the word expected from the coming edge, clock, then pop and compare.
   task automatic step(input string tag, input logic exp_set, input logic [24:0] exp_elem);
      logic [25:0] e;
      sb_q.push_back({exp_set, exp_elem});
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      check({tag, ".element"}, 32'(element), 32'(e[24:0]));
      check({tag, ".set_bit"}, 32'(set_bit), 32'(e[25]));
   endtask

   task automatic drive_row(input logic [3:0] nze);
      row_valid = 1'b1;
      row_nze   = nze;
   endtask

   task automatic drive_val(input logic v, input logic [23:0] d);
      elem_valid_in = v;
      elem_data_in  = d;
   endtask

   task automatic drain4(input string tag);
      for (int i = 0; i < 4; i++) begin
         check({tag, ".row_ready_in_drain"}, 32'(row_ready), 32'(0));
         step({tag, ".drain"}, 1'b0, 25'h0);
      end
      check({tag, ".row_ready_after"}, 32'(row_ready), 32'(1));
      check({tag, ".busy_after"}, 32'(busy), 32'(0));
   endtask

   initial begin
      reset = 1'b1;
      row_valid = 1'b0;
      row_nze = 4'd0;
      elem_valid_in = 1'b0;
      elem_data_in = 24'd0;
      #12;
      check("rst.element", 32'(element), 32'(0));
      check("rst.set_bit", 32'(set_bit), 32'(0));
      check("rst.busy", 32'(busy), 32'(0));
      check("rst.row_ready", 32'(row_ready), 32'(1));
      check("rst.elem_ready", 32'(elem_ready_in), 32'(0));
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Row 1: nze=3, values 5,7,9 back-to-back
      drive_row(4'd3);
      step("r1.accept", 1'b0, 25'h0);
      row_valid = 1'b0;
      check("r1.busy", 32'(busy), 32'(1));
      check("r1.elem_ready", 32'(elem_ready_in), 32'(1));
      check("r1.row_ready", 32'(row_ready), 32'(0));
      drive_val(1'b1, 24'd5);
      step("r1.w0", 1'b1, 25'h0000005);
      drive_val(1'b1, 24'd7);
      step("r1.w1", 1'b0, 25'h0000007);
      drive_val(1'b1, 24'd9);
      step("r1.w2", 1'b0, 25'h1000009);
      drive_val(1'b0, 24'd0);
      check("r1.elem_ready_drain", 32'(elem_ready_in), 32'(0));
      drain4("r1");

      // Row 2: empty row
      drive_row(4'd0);
      step("r2.empty", 1'b1, 25'h1000000);
      row_valid = 1'b0;
      drain4("r2");

      // Row 3: zeros before the last value
      drive_row(4'd3);
      step("r3.accept", 1'b0, 25'h0);
      row_valid = 1'b0;
      drive_val(1'b1, 24'd0);
      step("r3.z0", 1'b0, 25'h0);
      step("r3.z1", 1'b0, 25'h0);
      drive_val(1'b1, 24'd6);
      step("r3.last", 1'b1, 25'h1000006);
      drive_val(1'b0, 24'd0);
      drain4("r3");

      // Row 4: stall between values
      drive_row(4'd2);
      step("r4.accept", 1'b0, 25'h0);
      row_valid = 1'b0;
      drive_val(1'b1, 24'd3);
      step("r4.w0", 1'b1, 25'h0000003);
      drive_val(1'b0, 24'd99);
      for (int i = 0; i < 3; i++) step("r4.stall", 1'b0, 25'h0);
      drive_val(1'b1, 24'd4);
      step("r4.last", 1'b0, 25'h1000004);
      drive_val(1'b0, 24'd0);
      drain4("r4");

      // Row 5: nze=1 with zero data -> tag and set_bit on the same word
      drive_row(4'd1);
      step("r5.accept", 1'b0, 25'h0);
      row_valid = 1'b0;
      drive_val(1'b1, 24'd0);
      step("r5.last", 1'b1, 25'h1000000);
      drive_val(1'b0, 24'd0);
      drain4("r5");

      // Row 6: nze=15 with row_valid held high; next descriptor waits for drain
      drive_row(4'd15);
      step("r6.accept", 1'b0, 25'h0);
      row_nze = 4'd2;
      for (int i = 1; i <= 15; i++) begin
         drive_val(1'b1, 24'(i));
         step("r6.w", (i == 1), (i == 15) ? 25'h100000F : 25'(i));
      end
      drive_val(1'b0, 24'd0);
      for (int i = 0; i < 4; i++) begin
         check("r6.row_ready_in_drain", 32'(row_ready), 32'(0));
         step("r6.drain", 1'b0, 25'h0);
      end
      check("r6.row_ready_after", 32'(row_ready), 32'(1));
      step("r6.second_accept", 1'b0, 25'h0);
      row_valid = 1'b0;
      check("r6.second_busy", 32'(busy), 32'(1));
      drive_val(1'b1, 24'hA);
      step("r6b.w0", 1'b1, 25'h000000A);
      drive_val(1'b1, 24'hB);
      step("r6b.w1", 1'b0, 25'h100000B);
      drive_val(1'b0, 24'd0);
      drain4("r6b");

      // Row 7: reset mid-row, then a clean single-value row
      drive_row(4'd5);
      step("r7.accept", 1'b0, 25'h0);
      row_valid = 1'b0;
      drive_val(1'b1, 24'd1);
      step("r7.w0", 1'b1, 25'h0000001);
      drive_val(1'b1, 24'd2);
      step("r7.w1", 1'b0, 25'h0000002);
      drive_val(1'b0, 24'd0);
      reset = 1'b1;
      #1;
      check("r7.rst_element", 32'(element), 32'(0));
      check("r7.rst_set_bit", 32'(set_bit), 32'(0));
      check("r7.rst_busy", 32'(busy), 32'(0));
      check("r7.rst_row_ready", 32'(row_ready), 32'(1));
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      drive_row(4'd1);
      step("r8.accept", 1'b0, 25'h0);
      row_valid = 1'b0;
      drive_val(1'b1, 24'd8);
      step("r8.last", 1'b1, 25'h1000008);
      drive_val(1'b0, 24'd0);
      drain4("r8");

      check("sb.empty", 32'(sb_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
